run_control: RTL and testbench

Parametrised run controller for the CVA6 contract-synthesis harness. It gates instruction fetch on `NUM_CH` independent channels. Each channel is allowed exactly `max_count` fetches, then its fetch enable drops. The block counts multi-port retirements per channel and reports completion once every channel has retired `max_count` instructions. It sits between the testbench top and the cores' fetch and commit interfaces, and adds run-time loading, a retire-stall watchdog and over-retire error detection.

---
 rtl/run_control_pkg.sv | 34 +++
 rtl/run_control_ch.sv | 63 ++++++
 rtl/run_control.sv | 147 ++++++++++++++
 tb/tb_run_control.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/run_control_pkg.sv
// Shared types and helpers for the run controller: FSM state encoding,
// retire-increment width and a bit-count helper used per channel.
package run_control_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_DONE    = 3'd3,
    ST_TIMEOUT = 3'd4,
    ST_ERROR   = 3'd5
  } state_e;

  // Default commit width and the width needed to hold 0..NRET retires in one cycle.
  localparam int unsigned NRET_DEF = 2;
  localparam int unsigned RC_W     = $clog2(NRET_DEF + 1);

  // Widest retire group the helper accepts; the caller passes its real width in n.
  localparam int unsigned POP_W = 32;

  // Counts the set bits among the low n bits of a retire group.
  function automatic int unsigned popcount(input logic [POP_W-1:0] bits,
                                           input int unsigned n);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned i = 0; i < POP_W; i++) begin
      if (i < n && bits[i]) begin
        cnt++;
      end
    end
    return cnt;
  endfunction

endpackage

// File: rtl/run_control_ch.sv
// One fetch/retire channel: fetch counter, retire counter and fetch-enable flop.
// The status flags describe the values the counters take at the coming edge,
// so the controller can change state on the same edge the counters update.
module run_control_ch
  import run_control_pkg::*;
#(
  parameter int unsigned NRET  = 2,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             clear,          // start accepted: zero counters
  input  logic             arm,            // enable value loaded on clear
  input  logic             run,            // controller in RUN or DRAIN
  input  logic             kill,           // controller entering TIMEOUT/ERROR
  input  logic [CNT_W-1:0] max,
  input  logic             fetch,
  input  logic [NRET-1:0]  retire,
  output logic             enable,
  output logic             ch_fetch_done,  // enable low after this edge
  output logic             ch_retire_done, // retire count equals max after this edge
  output logic             ch_over         // retire count exceeds max after this edge
);

  logic [CNT_W-1:0] fetch_cnt_reg, fetch_cnt_next;
  logic [CNT_W:0]   retire_cnt_reg, retire_cnt_next;
  logic [CNT_W:0]   retire_inc;
  logic             enable_reg, enable_next;
  logic             fetch_hit;

  // Next-state values of the counters and enable, plus the look-ahead flags.
  always_comb begin
    fetch_hit       = enable_reg && fetch;
    fetch_cnt_next  = fetch_cnt_reg + CNT_W'(fetch_hit);
    enable_next     = enable_reg && !(fetch_hit && (fetch_cnt_next == max));
    // One extra bit of headroom means an over-retire is always visible, never wrapped.
    retire_inc      = (CNT_W+1)'(popcount(POP_W'(retire), NRET));
    retire_cnt_next = run ? (retire_cnt_reg + retire_inc) : retire_cnt_reg;
    ch_fetch_done   = !enable_next;
    ch_retire_done  = (retire_cnt_next == {1'b0, max});
    ch_over         = (retire_cnt_next > {1'b0, max});
  end

  // Counter and enable registers; a start reloads everything from scratch.
  always_ff @(posedge clk) begin
    if (srst) begin
      fetch_cnt_reg  <= '0;
      retire_cnt_reg <= '0;
      enable_reg     <= 1'b0;
    end else if (clear) begin
      fetch_cnt_reg  <= '0;
      retire_cnt_reg <= '0;
      enable_reg     <= arm;
    end else begin
      fetch_cnt_reg  <= fetch_cnt_next;
      retire_cnt_reg <= retire_cnt_next;
      enable_reg     <= enable_next && !kill;
    end
  end

  assign enable = enable_reg;

endmodule

// File: rtl/run_control.sv
// Run controller: gates fetch on NUM_CH channels to max_count instructions
// each, waits for all of them to retire, and flags completion, a retire-stall
// timeout or an over-retire error. All outputs are registered.
module run_control
  import run_control_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned NRET   = 2,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned TO_W   = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [CNT_W-1:0]       max_count_i,
  input  logic [TO_W-1:0]        timeout_i,
  input  logic [NUM_CH-1:0]      fetch_i,
  input  logic [NUM_CH*NRET-1:0] retire_i,
  output logic [NUM_CH-1:0]      enable_o,
  output logic                   busy_o,
  output logic                   finished_o,
  output logic                   timeout_o,
  output logic                   error_o
);

  state_e           state_reg;
  logic [CNT_W-1:0] max_cfg_reg;
  logic [TO_W-1:0]  timeout_cfg_reg;
  logic [TO_W-1:0]  idle_cnt_reg, idle_cnt_next;
  logic             busy_reg, finished_reg, timeout_flag_reg, error_reg;

  logic             run_active, start_ok, arm, kill;
  logic             any_retire, all_fetch_done, all_retire_done, any_over;
  logic             done_hit, idle_hit;
  logic             go_error, go_done, go_timeout, go_drain;

  logic [NUM_CH-1:0] fetch_done, retire_done, over;

  // Per-channel counters and fetch enables.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      run_control_ch #(
        .NRET  (NRET),
        .CNT_W (CNT_W)
      ) u_ch (
        .clk            (clk_i),
        .srst           (rst_i),
        .clear          (start_ok),
        .arm            (arm),
        .run            (run_active),
        .kill           (kill),
        .max            (max_cfg_reg),
        .fetch          (fetch_i[gi]),
        .retire         (retire_i[gi*NRET +: NRET]),
        .enable         (enable_o[gi]),
        .ch_fetch_done  (fetch_done[gi]),
        .ch_retire_done (retire_done[gi]),
        .ch_over        (over[gi])
      );
    end
  endgenerate

  // Cross-channel reductions, watchdog next value and prioritised transition requests.
  always_comb begin
    run_active      = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
    start_ok        = start_i && !run_active;
    arm             = (max_count_i != '0);
    any_retire      = |retire_i;
    all_fetch_done  = &fetch_done;
    all_retire_done = &retire_done;
    any_over        = |over;

    idle_cnt_next = idle_cnt_reg;
    if (run_active) begin
      if (any_retire) begin
        idle_cnt_next = '0;
      end else if (idle_cnt_reg != '1) begin
        idle_cnt_next = idle_cnt_reg + TO_W'(1);
      end
    end

    done_hit = all_fetch_done && all_retire_done;
    idle_hit = (timeout_cfg_reg != '0) && (idle_cnt_next == timeout_cfg_reg);

    go_error   = run_active && any_over;
    go_done    = run_active && !any_over && done_hit;
    go_timeout = run_active && !any_over && !done_hit && idle_hit;
    go_drain   = (state_reg == ST_RUN) && !any_over && !done_hit && !idle_hit
                 && all_fetch_done;
    // Abnormal ends shut every channel's fetch off on the same edge.
    kill       = go_error || go_timeout;
  end

  // Controller FSM with its configuration, watchdog and registered status flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg        <= ST_IDLE;
      max_cfg_reg      <= '0;
      timeout_cfg_reg  <= '0;
      idle_cnt_reg     <= '0;
      busy_reg         <= 1'b0;
      finished_reg     <= 1'b0;
      timeout_flag_reg <= 1'b0;
      error_reg        <= 1'b0;
    end else if (start_ok) begin
      max_cfg_reg      <= max_count_i;
      timeout_cfg_reg  <= timeout_i;
      idle_cnt_reg     <= '0;
      timeout_flag_reg <= 1'b0;
      error_reg        <= 1'b0;
      if (arm) begin
        state_reg    <= ST_RUN;
        busy_reg     <= 1'b1;
        finished_reg <= 1'b0;
      end else begin
        // Nothing to fetch: the run is complete immediately.
        state_reg    <= ST_DONE;
        busy_reg     <= 1'b0;
        finished_reg <= 1'b1;
      end
    end else if (run_active) begin
      idle_cnt_reg <= idle_cnt_next;
      if (go_error) begin
        state_reg <= ST_ERROR;
        busy_reg  <= 1'b0;
        error_reg <= 1'b1;
      end else if (go_done) begin
        state_reg    <= ST_DONE;
        busy_reg     <= 1'b0;
        finished_reg <= 1'b1;
      end else if (go_timeout) begin
        state_reg        <= ST_TIMEOUT;
        busy_reg         <= 1'b0;
        timeout_flag_reg <= 1'b1;
      end else if (go_drain) begin
        state_reg <= ST_DRAIN;
      end
    end
  end

  assign busy_o     = busy_reg;
  assign finished_o = finished_reg;
  assign timeout_o  = timeout_flag_reg;
  assign error_o    = error_reg;

endmodule

// File: tb/tb_run_control.sv
// Randomised and directed bench for run_control, checked every cycle against
// a behavioural model of the run rules kept in plain integer arithmetic.
module tb_run_control;

  localparam int NUM_CH = 2;
  localparam int NRET   = 2;
  localparam int CNT_W  = 32;
  localparam int TO_W   = 16;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   start = 1'b0;
  logic [CNT_W-1:0]       max_count = '0;
  logic [TO_W-1:0]        timeout = '0;
  logic [NUM_CH-1:0]      fetch = '0;
  logic [NUM_CH*NRET-1:0] retire = '0;
  logic [NUM_CH-1:0]      enable;
  logic                   busy, finished, timed_out, error;

  always #5 clk = ~clk;

  run_control #(
    .NUM_CH (NUM_CH),
    .NRET   (NRET),
    .CNT_W  (CNT_W),
    .TO_W   (TO_W)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .max_count_i (max_count),
    .timeout_i   (timeout),
    .fetch_i     (fetch),
    .retire_i    (retire),
    .enable_o    (enable),
    .busy_o      (busy),
    .finished_o  (finished),
    .timeout_o   (timed_out),
    .error_o     (error)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state.
  typedef enum int {M_IDLE, M_RUN, M_DRAIN, M_DONE, M_TIMEOUT, M_ERROR} mstate_t;
  mstate_t           m_state = M_IDLE;
  longint            m_max = 0;
  longint            m_to = 0;
  longint            m_idle = 0;
  bit [NUM_CH-1:0]   m_en = '0;
  longint            m_fetch [NUM_CH];
  longint            m_ret [NUM_CH];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advances the model by one clock edge using the currently driven inputs.
  task automatic model_step();
    bit over;
    bit all_eq;
    if (rst) begin
      m_state = M_IDLE;
      m_en    = '0;
      m_idle  = 0;
      for (int c = 0; c < NUM_CH; c++) begin
        m_fetch[c] = 0;
        m_ret[c]   = 0;
      end
    end else if (start && m_state != M_RUN && m_state != M_DRAIN) begin
      m_max  = longint'(max_count);
      m_to   = longint'(timeout);
      m_idle = 0;
      for (int c = 0; c < NUM_CH; c++) begin
        m_fetch[c] = 0;
        m_ret[c]   = 0;
      end
      if (m_max == 0) begin
        m_state = M_DONE;
        m_en    = '0;
      end else begin
        m_state = M_RUN;
        m_en    = '1;
      end
    end else if (m_state == M_RUN || m_state == M_DRAIN) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (m_en[c] && fetch[c]) begin
          m_fetch[c]++;
          if (m_fetch[c] == m_max) m_en[c] = 1'b0;
        end
        m_ret[c] += $countones(retire[c*NRET +: NRET]);
      end
      if (retire != '0) m_idle = 0;
      else if (m_idle < 65535) m_idle++;
      over   = 1'b0;
      all_eq = 1'b1;
      for (int c = 0; c < NUM_CH; c++) begin
        if (m_ret[c] > m_max) over = 1'b1;
        if (m_ret[c] != m_max) all_eq = 1'b0;
      end
      if (over) begin
        m_state = M_ERROR;
        m_en    = '0;
      end else if (m_en == '0 && all_eq) begin
        m_state = M_DONE;
      end else if (m_to != 0 && m_idle == m_to) begin
        m_state = M_TIMEOUT;
        m_en    = '0;
      end else if (m_state == M_RUN && m_en == '0) begin
        m_state = M_DRAIN;
      end
    end
  endtask

  // Drives one cycle of inputs, steps the model, and compares all outputs after the edge.
  task automatic step(input logic r, input logic s, input logic [CNT_W-1:0] mx,
                      input logic [TO_W-1:0] to, input logic [NUM_CH-1:0] f,
                      input logic [NUM_CH*NRET-1:0] rt, input string tag);
    @(negedge clk);
    rst       = r;
    start     = s;
    max_count = mx;
    timeout   = to;
    fetch     = f;
    retire    = rt;
    model_step();
    @(posedge clk);
    #1;
    $display("cycle %s rst=%0b start=%0b fetch=%b retire=%b -> en=%b busy=%0b fin=%0b to=%0b err=%0b",
             tag, r, s, f, rt, enable, busy, finished, timed_out, error);
    check({tag, ".en"},   64'(enable),    64'(m_en));
    check({tag, ".busy"}, 64'(busy),      64'(m_state == M_RUN || m_state == M_DRAIN));
    check({tag, ".fin"},  64'(finished),  64'(m_state == M_DONE));
    check({tag, ".to"},   64'(timed_out), 64'(m_state == M_TIMEOUT));
    check({tag, ".err"},  64'(error),     64'(m_state == M_ERROR));
  endtask

  initial begin
    logic [NUM_CH-1:0]      f;
    logic [NUM_CH*NRET-1:0] rt;
    logic [CNT_W-1:0]       mx;
    logic [TO_W-1:0]        to;
    int                     p;
    logic                   r0, r1;

    for (int c = 0; c < NUM_CH; c++) begin
      m_fetch[c] = 0;
      m_ret[c]   = 0;
    end

    // Reset, then strobes while idle must not disturb anything.
    step(1'b1, 1'b0, 0, 0, 2'b00, 4'b0000, "rst0");
    step(1'b1, 1'b0, 0, 0, 2'b11, 4'b1111, "rst1");
    check("rst.all_zero", 64'({enable, busy, finished, timed_out, error}), 64'd0);
    repeat (3) step(1'b0, 1'b0, 7, 3, 2'b11, 4'b1111, "idle");
    check("idle.all_zero", 64'({enable, busy, finished, timed_out, error}), 64'd0);

    // max=3, both channels fetch every cycle, retires 2 then 1 per channel.
    step(1'b0, 1'b1, 3, 0, 2'b00, 4'b0000, "m3.start");
    check("m3.start_en", 64'(enable), 64'd3);
    check("m3.start_busy", 64'(busy), 64'd1);
    step(1'b0, 1'b0, 0, 0, 2'b11, 4'b0000, "m3.a");
    step(1'b0, 1'b0, 0, 0, 2'b11, 4'b1111, "m3.b");
    step(1'b0, 1'b0, 0, 0, 2'b11, 4'b0101, "m3.c");
    check("m3.finished", 64'(finished), 64'd1);
    check("m3.busy_low", 64'(busy), 64'd0);
    check("m3.en_low", 64'(enable), 64'd0);

    // Uneven channels, max=4.
    step(1'b0, 1'b1, 4, 0, 2'b00, 4'b0000, "m4.start");
    for (int k = 1; k <= 10; k++) begin
      f[0] = (k <= 4);
      f[1] = (k >= 6 && k <= 9);
      r0   = (k >= 2 && k <= 5);
      r1   = (k >= 7);
      rt   = {1'b0, r1, 1'b0, r0};
      step(1'b0, 1'b0, 0, 0, f, rt, $sformatf("m4.k%0d", k));
      if (k >= 4 && k <= 8) check($sformatf("m4.en_split%0d", k), 64'(enable), 64'd2);
      if (k == 9) check("m4.drain_busy", 64'({busy, finished}), 64'b10);
      if (k == 10) check("m4.done", 64'(finished), 64'd1);
    end

    // Watchdog: max=2, timeout=5, one retire on ch1 then silence.
    step(1'b0, 1'b1, 2, 5, 2'b00, 4'b0000, "wd.start");
    step(1'b0, 1'b0, 0, 0, 2'b11, 4'b0000, "wd.f1");
    step(1'b0, 1'b0, 0, 0, 2'b11, 4'b0100, "wd.f2");
    for (int k = 1; k <= 5; k++) begin
      step(1'b0, 1'b0, 0, 0, 2'b00, 4'b0000, $sformatf("wd.s%0d", k));
      if (k < 5) check($sformatf("wd.quiet%0d", k), 64'(timed_out), 64'd0);
      else check("wd.fired", 64'({timed_out, enable}), 64'b100);
    end

    // Over-retire on ch0 coinciding with ch1 completing.
    step(1'b0, 1'b1, 2, 0, 2'b00, 4'b0000, "er.start");
    step(1'b0, 1'b0, 0, 0, 2'b11, 4'b0111, "er.a");
    step(1'b0, 1'b0, 0, 0, 2'b11, 4'b0101, "er.b");
    check("er.error", 64'({error, finished, enable}), 64'b1000);

    // max=0 goes straight to DONE; reset mid-run; restart from DONE.
    step(1'b0, 1'b1, 0, 0, 2'b11, 4'b0000, "z.start");
    check("z.done_no_en", 64'({finished, enable}), 64'b100);
    step(1'b0, 1'b0, 0, 0, 2'b11, 4'b1111, "z.hold");
    step(1'b0, 1'b1, 10, 0, 2'b00, 4'b0000, "r.start");
    repeat (3) step(1'b0, 1'b0, 0, 0, 2'b11, 4'b0001, "r.run");
    step(1'b1, 1'b1, 10, 0, 2'b11, 4'b1111, "r.reset");
    check("r.idle", 64'({enable, busy, finished, timed_out, error}), 64'd0);
    step(1'b0, 1'b1, 0, 0, 2'b00, 4'b0000, "c.done");
    step(1'b0, 1'b1, 2, 0, 2'b00, 4'b0000, "c.restart");
    step(1'b0, 1'b0, 0, 0, 2'b11, 4'b0101, "c.a");
    step(1'b0, 1'b0, 0, 0, 2'b11, 4'b0101, "c.b");
    check("c.clean_done", 64'(finished), 64'd1);

    // Randomised runs with occasional stray starts and resets.
    for (int run = 0; run < 40; run++) begin
      mx = CNT_W'($urandom_range(0, 5));
      to = TO_W'($urandom_range(0, 6));
      p  = int'($urandom_range(5, 35));
      step(1'b0, 1'b1, mx, to, 2'b00, 4'b0000, $sformatf("rnd%0d.start", run));
      for (int k = 0; k < 24; k++) begin
        f = NUM_CH'($urandom);
        for (int b = 0; b < NUM_CH*NRET; b++) rt[b] = ($urandom_range(0, 99) < p);
        step(($urandom_range(0, 79) == 0), ($urandom_range(0, 19) == 0),
             CNT_W'($urandom_range(0, 6)), TO_W'($urandom_range(0, 6)), f, rt,
             $sformatf("rnd%0d.%0d", run, k));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
